// File: rtl/raycaster_pkg.sv
// Shared fixed-point types, map geometry defaults and walker state encoding.
// Q16.16 scalars, {x,y} vectors, and the squared-distance miss sentinel.
package raycaster_pkg;

    typedef logic signed [31:0] fix_t;

    typedef struct packed {
        fix_t x;
        fix_t y;
    } vec_t;

    localparam int MAP_S      = 8;
    localparam int MAP_X      = MAP_S;
    localparam int MAP_Y      = MAP_S;
    localparam int CELL_SHIFT = 22;

    localparam logic [63:0] SQDIST_MISS = 64'hEFFF_FFFF_FFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE,
        H_WALK,
        V_WALK,
        DIST_H,
        DIST_V,
        DONE
    } march_state_e;

    function automatic fix_t to_fix(input int v);
        return fix_t'(v <<< 16);
    endfunction

endpackage

// File: rtl/vec_sq_dist.sv
// Combinational squared Euclidean distance between two Q16.16 vectors.
// Result is Q32.32; the sum of two squared 32-bit deltas always fits in 64 bits.
module vec_sq_dist (
    input  logic [63:0] a_i,
    input  logic [63:0] b_i,
    output logic [63:0] sq_o
);
    import raycaster_pkg::*;

    vec_t               a;
    vec_t               b;
    fix_t               run;
    fix_t               rise;
    logic signed [63:0] run_w;
    logic signed [63:0] rise_w;

    assign a      = vec_t'(a_i);
    assign b      = vec_t'(b_i);
    assign run    = a.x - b.x;
    assign rise   = a.y - b.y;
    assign run_w  = {{32{run[31]}}, run};
    assign rise_w = {{32{rise[31]}}, rise};
    assign sq_o   = run_w * run_w + rise_w * rise_w;

endmodule

// File: rtl/ray_march_unit.sv
// Per-column grid walker: probes horizontal then vertical gridline cells, returns nearer hit.
// Optional RAY_MARCH_STATS_EN adds res_probes_out and busy_cycles_out.
module ray_march_unit #(
    parameter int MAP_X      = raycaster_pkg::MAP_X,
    parameter int MAP_Y      = raycaster_pkg::MAP_Y,
    parameter int MAX_STEPS  = 8,
    parameter int CELL_SHIFT = raycaster_pkg::CELL_SHIFT
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     start_valid_in,
    output logic                     start_ready_out,
    input  logic [9:0]               col_in,
    input  logic [63:0]              origin_in,
    input  logic [63:0]              h_pos_in,
    input  logic [63:0]              h_step_in,
    input  logic                     h_en_in,
    input  logic [63:0]              v_pos_in,
    input  logic [63:0]              v_step_in,
    input  logic                     v_en_in,
    output logic [$clog2(MAP_X)-1:0] map_x_out,
    output logic [$clog2(MAP_Y)-1:0] map_y_out,
    input  logic                     map_hit_in,
    output logic                     res_valid_out,
    input  logic                     res_ready_in,
    output logic [9:0]               res_col_out,
    output logic                     res_is_vert_out,
    output logic                     res_hit_out,
`ifdef RAY_MARCH_STATS_EN
    output logic [$clog2(2*MAX_STEPS+1)-1:0] res_probes_out,
    output logic [31:0]              busy_cycles_out,
`endif
    output logic [63:0]              res_sqdist_out
);
    import raycaster_pkg::*;

    localparam int XW = $clog2(MAP_X);
    localparam int YW = $clog2(MAP_Y);
    localparam int CW = $clog2(MAX_STEPS + 1);
    localparam int IW = 32 - CELL_SHIFT;
    localparam logic [IW-1:0] X_LIM = IW'(MAP_X);
    localparam logic [IW-1:0] Y_LIM = IW'(MAP_Y);
    localparam logic [CW-1:0] LAST  = CW'(MAX_STEPS - 1);

    march_state_e  state_q, state_d;
    logic [9:0]    col_q, col_d;
    vec_t          org_q, org_d;
    vec_t          hpos_q, hpos_d, hstep_q, hstep_d;
    vec_t          vpos_q, vpos_d, vstep_q, vstep_d;
    logic          ven_q, ven_d;
    logic          hhit_q, hhit_d, vhit_q, vhit_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [63:0]   hsq_q, hsq_d;
    logic [9:0]    rcol_q, rcol_d;
    logic          rvert_q, rvert_d, rhit_q, rhit_d;
    logic [63:0]   rsq_q, rsq_d;

    vec_t          cur;
    vec_t          dist_pt;
    logic [IW-1:0] cx, cy;
    logic          walk, oob, hit, fam_end;
    logic [63:0]   sq, vsq;

    assign walk    = (state_q == H_WALK) || (state_q == V_WALK);
    assign cur     = (state_q == V_WALK) ? vpos_q : hpos_q;
    assign cx      = cur.x[31:CELL_SHIFT];
    assign cy      = cur.y[31:CELL_SHIFT];
    // Sign bit catches points left of / above the map before the index compare.
    assign oob     = cur.x[31] | cur.y[31] | (cx >= X_LIM) | (cy >= Y_LIM);
    assign hit     = ~oob & map_hit_in;
    assign fam_end = oob | map_hit_in | (cnt_q == LAST);

    assign map_x_out = walk ? cur.x[CELL_SHIFT+XW-1:CELL_SHIFT] : '0;
    assign map_y_out = walk ? cur.y[CELL_SHIFT+YW-1:CELL_SHIFT] : '0;

    assign dist_pt = (state_q == DIST_V) ? vpos_q : hpos_q;

    vec_sq_dist u_dist (
        .a_i  (dist_pt),
        .b_i  (org_q),
        .sq_o (sq)
    );

    assign vsq = vhit_q ? sq : SQDIST_MISS;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        org_d   = org_q;
        hpos_d  = hpos_q;
        hstep_d = hstep_q;
        vpos_d  = vpos_q;
        vstep_d = vstep_q;
        ven_d   = ven_q;
        hhit_d  = hhit_q;
        vhit_d  = vhit_q;
        cnt_d   = cnt_q;
        hsq_d   = hsq_q;
        rcol_d  = rcol_q;
        rvert_d = rvert_q;
        rhit_d  = rhit_q;
        rsq_d   = rsq_q;
        case (state_q)
            IDLE: if (start_valid_in) begin
                col_d   = col_in;
                org_d   = vec_t'(origin_in);
                hpos_d  = vec_t'(h_pos_in);
                hstep_d = vec_t'(h_step_in);
                vpos_d  = vec_t'(v_pos_in);
                vstep_d = vec_t'(v_step_in);
                ven_d   = v_en_in;
                hhit_d  = 1'b0;
                vhit_d  = 1'b0;
                cnt_d   = '0;
                state_d = h_en_in ? H_WALK : (v_en_in ? V_WALK : DIST_H);
            end
            H_WALK: begin
                hhit_d = hit;
                if (fam_end) begin
                    cnt_d   = '0;
                    state_d = ven_q ? V_WALK : DIST_H;
                end else begin
                    hpos_d.x = hpos_q.x + hstep_q.x;
                    hpos_d.y = hpos_q.y + hstep_q.y;
                    cnt_d    = cnt_q + 1'b1;
                end
            end
            V_WALK: begin
                vhit_d = hit;
                if (fam_end) begin
                    cnt_d   = '0;
                    state_d = DIST_H;
                end else begin
                    vpos_d.x = vpos_q.x + vstep_q.x;
                    vpos_d.y = vpos_q.y + vstep_q.y;
                    cnt_d    = cnt_q + 1'b1;
                end
            end
            DIST_H: begin
                hsq_d   = hhit_q ? sq : SQDIST_MISS;
                state_d = DIST_V;
            end
            DIST_V: begin
                rcol_d  = col_q;
                rvert_d = vsq < hsq_q;
                rsq_d   = (vsq < hsq_q) ? vsq : hsq_q;
                rhit_d  = hhit_q | vhit_q;
                state_d = DONE;
            end
            DONE: if (res_ready_in) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            col_q   <= '0;
            org_q   <= '0;
            hpos_q  <= '0;
            hstep_q <= '0;
            vpos_q  <= '0;
            vstep_q <= '0;
            ven_q   <= 1'b0;
            hhit_q  <= 1'b0;
            vhit_q  <= 1'b0;
            cnt_q   <= '0;
            hsq_q   <= '0;
            rcol_q  <= '0;
            rvert_q <= 1'b0;
            rhit_q  <= 1'b0;
            rsq_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            org_q   <= org_d;
            hpos_q  <= hpos_d;
            hstep_q <= hstep_d;
            vpos_q  <= vpos_d;
            vstep_q <= vstep_d;
            ven_q   <= ven_d;
            hhit_q  <= hhit_d;
            vhit_q  <= vhit_d;
            cnt_q   <= cnt_d;
            hsq_q   <= hsq_d;
            rcol_q  <= rcol_d;
            rvert_q <= rvert_d;
            rhit_q  <= rhit_d;
            rsq_q   <= rsq_d;
        end
    end

    assign start_ready_out = (state_q == IDLE);
    assign res_valid_out   = (state_q == DONE);
    assign res_col_out     = rcol_q;
    assign res_is_vert_out = rvert_q;
    assign res_hit_out     = rhit_q;
    assign res_sqdist_out  = rsq_q;

`ifdef RAY_MARCH_STATS_EN
    logic [$clog2(2*MAX_STEPS+1)-1:0] probes_q;
    logic [31:0]                      busy_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            probes_q <= '0;
            busy_q   <= '0;
        end else begin
            if (state_q != IDLE) busy_q <= busy_q + 32'd1;
            if (state_q == IDLE && start_valid_in) probes_q <= '0;
            else if (walk) probes_q <= probes_q + 1'b1;
        end
    end

    assign res_probes_out  = probes_q;
    assign busy_cycles_out = busy_q;
`endif

endmodule
